// File: rtl/ptcalc_div_pkg.sv
// Shared widths, FSM states and result record for the ptcalc sequential signed divider.
package ptcalc_div_pkg;
   localparam int DIVIDEND_W = 31;
   localparam int DIVISOR_W  = 12;
   localparam int QUOT_W     = 19;

   localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
   localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   typedef struct packed {
      logic [QUOT_W-1:0]    quotient;
      logic [DIVISOR_W-1:0] remainder;
      logic                 div_zero;
      logic                 ovf;
   } div_res_t;
endpackage

// File: rtl/ptcalc_div_iter.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, subtract |D| if it fits.
module ptcalc_div_iter
   import ptcalc_div_pkg::*;
#(
   parameter int DW = DIVISOR_W
) (
   input  logic [DW:0]   rem,
   input  logic [DW-1:0] dmag,
   input  logic          nbit,
   output logic [DW:0]   rem_next,
   output logic          qbit
);
   logic [DW:0] shifted;

   always_comb begin
      shifted  = {rem[DW-1:0], nbit};
      qbit     = (shifted >= {1'b0, dmag});
      rem_next = qbit ? (shifted - {1'b0, dmag}) : shifted;
   end
endmodule

// File: rtl/ptcalc_top_sdiv_seq.sv
// Sequential signed divider, one quotient bit per clock; result valid DIVIDEND_WIDTH+2 cycles after accept.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module ptcalc_top_sdiv_seq
   import ptcalc_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_W,
   parameter int DIVISOR_WIDTH  = DIVISOR_W,
   parameter int QUOT_WIDTH     = QUOT_W
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOT_WIDTH-1:0]     quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_zero,
   output logic                      ovf
);
   localparam int CNT_W = $clog2(DIVIDEND_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DIVIDEND_WIDTH - 1);
   localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = DIVIDEND_WIDTH'(QUOT_MAX);
   localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = DIVIDEND_WIDTH'(QUOT_MIN);

   state_t                    state, state_next;
   logic [CNT_W-1:0]          cnt;
   logic [DIVIDEND_WIDTH-1:0] n_shift;
   logic [DIVIDEND_WIDTH-1:0] q;
   logic [DIVISOR_WIDTH-1:0]  d_mag;
   logic [DIVISOR_WIDTH:0]    r, r_next;
   logic                      q_bit, q_neg, r_neg, dz;
   div_res_t                  res, res_fix;

   ptcalc_div_iter #(.DW(DIVISOR_WIDTH)) u_iter (
      .rem      (r),
      .dmag     (d_mag),
      .nbit     (n_shift[DIVIDEND_WIDTH-1]),
      .rem_next (r_next),
      .qbit     (q_bit)
   );

   always_comb begin
      state_next = state;
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      case (state)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (cnt == LAST_BIT) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Sign application and saturation of the unsigned magnitude result.
   always_comb begin
      res_fix = '0;
      if (dz) begin
         res_fix.div_zero = 1'b1;
         res_fix.quotient = r_neg ? QUOT_MIN : QUOT_MAX;
      end else begin
         res_fix.remainder = r_neg ? -r[DIVISOR_WIDTH-1:0] : r[DIVISOR_WIDTH-1:0];
         if (!q_neg && (q > POS_LIMIT)) begin
            res_fix.quotient = QUOT_MAX;
            res_fix.ovf      = 1'b1;
         end else if (q_neg && (q > NEG_LIMIT)) begin
            res_fix.quotient = QUOT_MIN;
            res_fix.ovf      = 1'b1;
         end else begin
            res_fix.quotient = q_neg ? -q[QUOT_WIDTH-1:0] : q[QUOT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         n_shift <= '0;
         q       <= '0;
         d_mag   <= '0;
         r       <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         dz      <= 1'b0;
         res     <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (in_valid) begin
               n_shift <= dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
               d_mag   <= divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
               q_neg   <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
               r_neg   <= dividend[DIVIDEND_WIDTH-1];
               dz      <= (divisor == '0);
               cnt     <= '0;
               r       <= '0;
               q       <= '0;
            end
            CALC: begin
               n_shift <= n_shift << 1;
               r       <= r_next;
               q       <= {q[DIVIDEND_WIDTH-2:0], q_bit};
               cnt     <= cnt + 1'b1;
            end
            FIX:     res <= res_fix;
            default: ;
         endcase
      end
   end

   assign quotient  = res.quotient;
   assign remainder = res.remainder;
   assign div_zero  = res.div_zero;
   assign ovf       = res.ovf;
endmodule

// File: tb/tb_ptcalc_top_sdiv_seq.sv
// Directed-vector bench for the sequential signed divider.
module tb_ptcalc_top_sdiv_seq;
   localparam int LAT = 31 + 2;

   logic        ap_clk = 1'b0;
   logic        ap_rst, in_valid, out_ready;
   logic [30:0] dividend;
   logic [11:0] divisor;
   logic        in_ready, out_valid, div_zero, ovf;
   logic [18:0] quotient;
   logic [11:0] remainder;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int n; int d; int q; int r; bit z; bit o;
   } vec_t;

   ptcalc_top_sdiv_seq dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero), .ovf(ovf)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one operand pair, returns cycles from accept cycle to first out_valid (-1 on timeout).
   task automatic run_op(input int n, input int d, output int lat);
      @(negedge ap_clk);
      dividend = 31'(n);
      divisor  = 12'(d);
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_zero, ovf} !== {1'b1, 1'b0, 33'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 vld=0 rest 0",
                  in_ready, out_valid, quotient, remainder, div_zero, ovf);
      end
      @(negedge ap_clk);
      ap_rst = 1'b0;
   endtask

   task automatic test_vectors(input string name, input vec_t v[$]);
      int lat;
      logic [32:0] exp_r, got_r;
      foreach (v[i]) begin
         run_op(v[i].n, v[i].d, lat);
         exp_r = {19'(v[i].q), 12'(v[i].r), v[i].z, v[i].o};
         got_r = {quotient, remainder, div_zero, ovf};
         n_cmp++;
         if (lat != LAT) begin
            n_bad++;
            $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, LAT);
         end
         n_cmp++;
         if (got_r !== exp_r) begin
            n_bad++;
            $display("FAIL %s[%0d] %0d/%0d: got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=%b ovf=%b",
                     name, i, v[i].n, v[i].d, quotient, remainder, div_zero, ovf,
                     exp_r[32:14], exp_r[13:2], exp_r[1], exp_r[0]);
         end
         consume();
      end
   endtask

   task automatic test_signed_div();
      vec_t v[$];
      v = '{'{1000000, 37, 27027, 1, 0, 0},
            '{-1000000, 37, -27027, -1, 0, 0},
            '{1000000, -37, -27027, 1, 0, 0},
            '{-1000000, -37, 27027, -1, 0, 0},
            '{-185184000, 1500, -123456, 0, 0, 0},
            '{100000, -2048, -48, 1696, 0, 0}};
      test_vectors("signed_div", v);
   endtask

   task automatic test_saturation();
      vec_t v[$];
      v = '{'{1073741823, 1, 262143, 0, 0, 1},
            '{-1073741824, 1, -262144, 0, 0, 1},
            '{-1073741824, -2048, 262143, 0, 0, 1},
            '{262143, 1, 262143, 0, 0, 0},
            '{-262144, 1, -262144, 0, 0, 0}};
      test_vectors("saturation", v);
   endtask

   task automatic test_div_zero();
      vec_t v[$];
      v = '{'{5, 0, 262143, 0, 1, 0},
            '{-7, 0, -262144, 0, 1, 0},
            '{0, 0, 262143, 0, 1, 0}};
      test_vectors("div_zero", v);
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [32:0] first_r, exp2;
      run_op(1000000, 37, lat);
      first_r = {quotient, remainder, div_zero, ovf};
      n_cmp++;
      if (first_r !== {19'(27027), 12'(1), 2'b00}) begin
         n_bad++;
         $display("FAIL hold_first: got %h want %h", first_r, {19'(27027), 12'(1), 2'b00});
      end
      @(negedge ap_clk);
      dividend = 31'(-185184000);
      divisor  = 12'(1500);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge ap_clk); #1;
         n_cmp++;
         if ({out_valid, in_ready, quotient, remainder, div_zero, ovf} !== {1'b1, 1'b0, first_r}) begin
            n_bad++;
            $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                     i, out_valid, in_ready, {quotient, remainder, div_zero, ovf}, first_r);
         end
      end
      consume();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      exp2 = {19'(-123456), 12'(0), 2'b00};
      n_cmp++;
      if (lat != LAT || {quotient, remainder, div_zero, ovf} !== exp2) begin
         n_bad++;
         $display("FAIL second_op: got lat=%0d res=%h want lat=%0d res=%h",
                  lat, {quotient, remainder, div_zero, ovf}, LAT, exp2);
      end
      consume();
   endtask

   task automatic test_reset_mid_op();
      int lat;
      bit seen;
      vec_t v[$];
      @(negedge ap_clk);
      dividend = 31'(123456789);
      divisor  = 12'(7);
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      repeat (14) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_zero, ovf} !== {1'b1, 1'b0, 33'b0}) begin
         n_bad++;
         $display("FAIL mid_reset: got rdy=%b vld=%b q=%h r=%h dz=%b ovf=%b, want rdy=1 vld=0 rest 0",
                  in_ready, out_valid, quotient, remainder, div_zero, ovf);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge ap_clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL aborted_result: got out_valid seen=%b want 0", seen);
      end
      v = '{'{-1000000, 37, -27027, -1, 0, 0}};
      test_vectors("after_reset", v);
   endtask

   initial begin
      ap_rst    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      test_reset();
      test_signed_div();
      test_saturation();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
